mips_data_mem_ctrl: RTL and testbench
=====================================

Name: mips_data_mem_ctrl

Overview:
Parametrised successor to the single-cycle data memory. It adds byte, halfword and word accesses, configurable wait states with a req/ready handshake so the core can stall, alignment checking and a parametrised debug tap. It sits between the MIPS core's ALU-result/write-data/mem-write outputs and the top level's test_value output.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (lanes = DATA_WIDTH/8, fixed at 4 for this generation).
DEPTH, 64, number of words; power of 2.
ADDR_WIDTH, 32, byte-address width.
WAIT_STATES, 2, extra cycles per access, 0..15.
TEST_WORD, 0, word index exported on test_value.
TEST_WIDTH, 16, width of test_value, taken from the LSBs of that word.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low; clears all state and memory.
req  in  1  access request, sampled in IDLE only.
we  in  1  1 = store, 0 = load.
size  in  2  00 byte, 01 half, 10 word, 11 illegal.
sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend.
addr  in  ADDR_WIDTH  byte address.
wdata  in  DATA_WIDTH  store data, right-justified.
rdata  out  DATA_WIDTH  load result, valid while ready=1.
ready  out  1  one-cycle completion pulse.
busy  out  1  high whenever state != IDLE.
misalign_err  out  1  high with ready when the access was rejected.
test_value  out  TEST_WIDTH  mem[TEST_WORD][TEST_WIDTH-1:0].

Behaviour:
- Reset (reset=0, asynchronous): state = IDLE; rdata = 0; ready = 0; busy = 0; misalign_err = 0; every memory word = 0; wait counter = 0; any pending store is discarded.
- FSM states: IDLE, WAIT, DONE.
- IDLE with req=1 at a clock edge:
  - Capture addr, we, size, sign_ext and wdata.
  - If misaligned or size=11: go to DONE with the error flag set.
  - Else if WAIT_STATES=0: go to DONE.
  - Else: go to WAIT with counter = WAIT_STATES-1.
- WAIT: decrement the counter each edge; on the edge where counter==0, go to DONE.
- The memory access (store or load) is performed on the edge entering DONE.
- DONE: ready=1 for exactly one cycle, then IDLE unconditionally. req is ignored in WAIT and DONE; it is re-sampled from IDLE on the next edge.
- Latency: ready is high in the cycle following the (WAIT_STATES+1)th edge after acceptance. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - An error performs no store; rdata=0 and misalign_err=1 with ready.
- Word index is addr[log2(DEPTH)+1:2]; upper bits are ignored, so accesses wrap modulo DEPTH words.
- Little-endian lanes; lane k = bits 8k+7:8k.
  - Byte store: lane addr[1:0] <= wdata[7:0].
  - Half store: lanes {2*addr[1]+1, 2*addr[1]} <= wdata[15:0].
  - Word store: all lanes. Untouched lanes keep their value.
- Loads: extract the same lanes, right-justify, then sign- or zero-extend to DATA_WIDTH. Word loads ignore sign_ext.
- Stores return rdata=0.
- test_value is combinational from the array and reflects a store from the cycle after the store edge.
- Reset asserted during WAIT/DONE aborts the access with no partial write. Deassertion returns to IDLE; req is sampled from the first edge after deassertion.

Decomposition:
- Package mips_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state encoding S_IDLE, S_WAIT, S_DONE;
  - LANES = DATA_WIDTH/8.
- Sub-module mem_lane_align: purely combinational. Inputs are the old word, wdata, size, offset and sign_ext. Outputs are the merged store word, the extended load value and the misalign flag. The controller contains only the FSM, counter, capture registers and array.

Test Plan:
- Reset and defaults, WAIT_STATES=2: word store 0xDEADBEEF to addr 0x0, then word load at 0x0 -> ready exactly 3 edges after acceptance, rdata=0xDEADBEEF, busy high for 3 cycles, test_value=0xBEEF.
- Byte/half merge: word 0x11223344 at 0x4; byte store 0xAA at 0x6; half store 0x5566 at 0x4 -> word load at 0x4 = 0x11AA5566.
- Load extension, with mem[0x8]=0x000080F0:
  - byte load 0x8, sign_ext=1 -> 0xFFFFFFF0;
  - byte load 0x8, sign_ext=0 -> 0x000000F0;
  - half load 0x8, sign_ext=1 -> 0xFFFF80F0.
- Misalignment: word store to 0x2 and half load at 0x1 -> misalign_err=1 with ready, rdata=0, memory unchanged; size=11 at 0x0 -> misalign_err=1.
- Wrap and handshake: DEPTH=64, store 0x12345678 at 0x100 -> load at 0x0 returns 0x12345678. Hold req high continuously -> a new access starts every 4 cycles, none accepted in WAIT/DONE.
- Reset mid-operation: store 0xCAFEF00D issued, reset pulsed low during WAIT -> ready never pulses; after release, load at that address = 0, test_value=0. Repeat with WAIT_STATES=0 -> ready on the first edge after acceptance.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory controller.
//   LANES          : byte lanes per word (fixed at 4 for this generation)
//   SZ_*           : access size encodings on the 'size' port (2'b11 is illegal)
//   state_t        : controller FSM states
package mips_mem_pkg;

   localparam int LANES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the data memory.
//   old_word  : current contents of the addressed word
//   wdata     : right-justified store data
//   size      : SZ_BYTE / SZ_HALF / SZ_WORD (2'b11 illegal)
//   offset    : byte offset within the word (addr[1:0])
//   sign_ext  : loads only, 1 = sign-extend the extracted lanes
//   st_word   : old_word with the store lanes replaced
//   ld_word   : extracted lanes, right-justified and extended
//   misalign  : access is misaligned or uses the illegal size
module mem_lane_align
   import mips_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] old_word,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [1:0]            size,
   input  logic [1:0]            offset,
   input  logic                  sign_ext,
   output logic [DATA_WIDTH-1:0] st_word,
   output logic [DATA_WIDTH-1:0] ld_word,
   output logic                  misalign
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Little-endian: lane k occupies bits 8k+7:8k; halves use lanes {2*offset[1]+1, 2*offset[1]}.
   assign ld_byte = old_word[{offset, 3'b000} +: 8];
   assign ld_half = old_word[{offset[1], 4'b0000} +: 16];

   always_comb begin
      st_word  = old_word;
      ld_word  = '0;
      misalign = 1'b0;
      case (size)
         SZ_BYTE: begin
            st_word[{offset, 3'b000} +: 8] = wdata[7:0];
            ld_word = {{(DATA_WIDTH-8){sign_ext & ld_byte[7]}}, ld_byte};
         end
         SZ_HALF: begin
            misalign = offset[0];
            st_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            ld_word = {{(DATA_WIDTH-16){sign_ext & ld_half[15]}}, ld_half};
         end
         SZ_WORD: begin
            misalign = |offset;
            st_word  = wdata;
            ld_word  = old_word;
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_data_mem_ctrl.sv
// MIPS data memory with byte/half/word access, wait states and a req/ready handshake.
//   clk, reset     : rising-edge clock, async active-low reset (clears memory too)
//   req            : access request, sampled in IDLE only
//   we, size, sign_ext, addr, wdata : access descriptor, captured on acceptance
//   rdata          : load result (0 for stores and rejected accesses), valid with ready
//   ready          : one-cycle completion pulse
//   busy           : controller is not IDLE
//   misalign_err   : with ready, the access was rejected
//   test_value     : low TEST_WIDTH bits of word TEST_WORD
module mips_data_mem_ctrl
   import mips_mem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_STATES = 2,
   parameter int TEST_WORD   = 0,
   parameter int TEST_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic                  busy,
   output logic                  misalign_err,
   output logic [TEST_WIDTH-1:0] test_value
);

   localparam int         IDX_W   = $clog2(DEPTH);
   localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic [IDX_W+1:0]      addr_q;
   logic                  we_q, sx_q, err_q;
   logic [1:0]            size_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  idle, enter_done;
   logic [IDX_W+1:0]      a_e;
   logic                  we_e, sx_e;
   logic [1:0]            size_e;
   logic [DATA_WIDTH-1:0] wdata_e, st_word, ld_word;
   logic                  misalign;
   logic                  unused_addr;

   // Upper address bits wrap the array and are deliberately dropped.
   assign unused_addr = ^addr[ADDR_WIDTH-1:IDX_W+2];

   // With zero wait states the access happens on the acceptance edge itself,
   // so the live inputs are steered in while IDLE; otherwise the captured copy.
   assign idle    = (state == S_IDLE);
   assign a_e     = idle ? addr[IDX_W+1:0] : addr_q;
   assign we_e    = idle ? we       : we_q;
   assign sx_e    = idle ? sign_ext : sx_q;
   assign size_e  = idle ? size     : size_q;
   assign wdata_e = idle ? wdata    : wdata_q;

   mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .old_word (mem[a_e[IDX_W+1:2]]),
      .wdata    (wdata_e),
      .size     (size_e),
      .offset   (a_e[1:0]),
      .sign_ext (sx_e),
      .st_word  (st_word),
      .ld_word  (ld_word),
      .misalign (misalign)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req) state_nxt = (misalign || WAIT_STATES == 0) ? S_DONE : S_WAIT;
         S_WAIT:  if (cnt == 4'd0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         sx_q    <= 1'b0;
         size_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nxt;
         if (idle && req) begin
            addr_q  <= addr[IDX_W+1:0];
            we_q    <= we;
            sx_q    <= sign_ext;
            size_q  <= size;
            wdata_q <= wdata;
            cnt     <= WS_INIT;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_done) begin
            err_q <= misalign;
            rdata <= (misalign || we_e) ? '0 : ld_word;
            if (!misalign && we_e) mem[a_e[IDX_W+1:2]] <= st_word;
         end
      end
   end

   assign ready        = (state == S_DONE);
   assign busy         = !idle;
   assign misalign_err = ready & err_q;
   assign test_value   = mem[TEST_WORD][TEST_WIDTH-1:0];

endmodule

// File: tb/tb_mips_data_mem_ctrl.sv
module tb_mips_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0, req0 = 1'b0;
   logic        we = 1'b0, sign_ext = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata, rdata0;
   logic        ready, ready0, busy, busy0, err, err0;
   logic [15:0] tv, tv0;

   int vecs = 0;
   int miss = 0;

   always #5 clk = ~clk;

   mips_data_mem_ctrl #(.WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
      .misalign_err(err), .test_value(tv)
   );

   mips_data_mem_ctrl #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0),
      .misalign_err(err0), .test_value(tv0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One access; ready is expected WAIT_STATES+1 edges after acceptance
   // (counting the acceptance edge), or one edge for WS=0 / rejected accesses.
   task automatic acc(input bit d0, input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
      int n, b, lat;
      lat = (d0 || exp_err) ? 1 : 3;
      @(negedge clk);
      we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
      if (d0) req0 = 1'b1; else req = 1'b1;
      @(negedge clk);
      req = 1'b0; req0 = 1'b0;
      n = 1; b = 0;
      while (!(d0 ? ready0 : ready) && n < 20) begin
         if (d0 ? busy0 : busy) b++;
         @(negedge clk);
         n++;
      end
      if (d0 ? busy0 : busy) b++;
      chk({tag, " latency"}, n, lat);
      chk({tag, " busy cycles"}, b, lat);
      chk({tag, " rdata"}, d0 ? rdata0 : rdata, exp_rd);
      chk({tag, " misalign_err"}, {31'd0, d0 ? err0 : err}, {31'd0, exp_err});
   endtask

   initial begin
      int np, last;
      bit seen;

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst rdata", rdata, 32'h0);
      chk("rst ready", {31'd0, ready}, 32'h0);
      chk("rst busy", {31'd0, busy}, 32'h0);
      chk("rst err", {31'd0, err}, 32'h0);
      chk("rst test_value", {16'd0, tv}, 32'h0);
      reset = 1'b1;

      // basic word store/load
      acc(0, 1, 2'b10, 0, 32'h0, 32'hDEADBEEF, 32'h0, 0, "st word 0");
      chk("test_value after store", {16'd0, tv}, 32'h0000BEEF);
      acc(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'hDEADBEEF, 0, "ld word 0");

      // byte/half merge
      acc(0, 1, 2'b10, 0, 32'h4, 32'h11223344, 32'h0, 0, "st word 4");
      acc(0, 1, 2'b00, 0, 32'h6, 32'h000000AA, 32'h0, 0, "st byte 6");
      acc(0, 1, 2'b01, 0, 32'h4, 32'h00005566, 32'h0, 0, "st half 4");
      acc(0, 0, 2'b10, 0, 32'h4, 32'h0, 32'h11AA5566, 0, "ld merged 4");

      // load extension
      acc(0, 1, 2'b10, 0, 32'h8, 32'h000080F0, 32'h0, 0, "st word 8");
      acc(0, 0, 2'b00, 1, 32'h8, 32'h0, 32'hFFFFFFF0, 0, "ld byte 8 sx");
      acc(0, 0, 2'b00, 0, 32'h8, 32'h0, 32'h000000F0, 0, "ld byte 8 zx");
      acc(0, 0, 2'b01, 1, 32'h8, 32'h0, 32'hFFFF80F0, 0, "ld half 8 sx");
      acc(0, 0, 2'b01, 0, 32'h8, 32'h0, 32'h000080F0, 0, "ld half 8 zx");
      acc(0, 0, 2'b00, 1, 32'h9, 32'h0, 32'hFFFFFF80, 0, "ld byte 9 sx");
      acc(0, 0, 2'b00, 1, 32'hB, 32'h0, 32'h00000000, 0, "ld byte B sx");
      acc(0, 0, 2'b10, 1, 32'h8, 32'h0, 32'h000080F0, 0, "ld word 8 sx");

      // misalignment / illegal size
      acc(0, 1, 2'b10, 0, 32'h2, 32'h99999999, 32'h0, 1, "st word 2 misal");
      acc(0, 0, 2'b01, 1, 32'h1, 32'h0, 32'h0, 1, "ld half 1 misal");
      acc(0, 1, 2'b01, 0, 32'h3, 32'h00007777, 32'h0, 1, "st half 3 misal");
      acc(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, "size 11");
      acc(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'hDEADBEEF, 0, "ld word 0 unchanged");
      chk("test_value unchanged", {16'd0, tv}, 32'h0000BEEF);

      // address wrap
      acc(0, 1, 2'b10, 0, 32'h100, 32'h12345678, 32'h0, 0, "st word 100");
      acc(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, "ld wrap 0");
      chk("test_value wrap", {16'd0, tv}, 32'h00005678);

      // req held high: one access per 4 cycles
      @(negedge clk);
      we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h0; req = 1'b1;
      np = 0; last = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (ready) begin
            if (np > 0) chk("pipelined spacing", i - last, 4);
            chk("pipelined rdata", rdata, 32'h12345678);
            last = i;
            np++;
         end
      end
      req = 1'b0;
      chk("pipelined pulses", np, 3);

      // reset during WAIT aborts the store
      @(negedge clk);
      we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hCAFEF00D; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("pre-abort busy", {31'd0, busy}, 32'h1);
      reset = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (ready) seen = 1'b1; end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (ready) seen = 1'b1; end
      chk("abort no ready", {31'd0, seen}, 32'h0);
      chk("abort test_value", {16'd0, tv}, 32'h0);
      acc(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, "ld aborted 10");

      // zero wait states
      acc(1, 1, 2'b10, 0, 32'h0, 32'h0000A5A5, 32'h0, 0, "ws0 st word 0");
      chk("ws0 test_value", {16'd0, tv0}, 32'h0000A5A5);
      acc(1, 0, 2'b00, 1, 32'h0, 32'h0, 32'hFFFFFFA5, 0, "ws0 ld byte 0 sx");
      acc(1, 0, 2'b10, 0, 32'h1, 32'h0, 32'h0, 1, "ws0 misal");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
